// File: rtl/keypad_entry_scanner.sv
// 4x4 active-low key matrix scanner with full-scan debounce, one event per press,
// and a 3-digit BCD entry register committed by the Enter key.
module keypad_entry_scanner #(
  parameter int SCAN_BITS      = 11,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [11:0] entry_value,
  output logic        entry_done,
  output logic [11:0] commit_value
);

  typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} kind_e;

  localparam logic [3:0] DB    = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] K_CLR = 4'hC;
  localparam logic [3:0] K_ENT = 4'hE;

  logic [3:0]           row_m_q, row_s_q;
  logic [SCAN_BITS-1:0] dwell_q;
  logic [1:0]           ci_q;
  logic [1:0]           acc_n_q;   // low rows seen this scan, saturating at 2
  logic [3:0]           acc_k_q;
  kind_e                prev_kind_q, stab_kind_q;
  logic [3:0]           prev_key_q, stab_key_q;
  logic [3:0]           stab_cnt_q;

  logic                 tc, scan_end, same;
  logic [2:0]           col_n, sum;
  logic [1:0]           col_r, acc_n_d;
  logic [3:0]           acc_k_d, res_key, cnt_d;
  kind_e                res_kind;

  assign col_out  = ~(4'b0001 << ci_q);
  assign tc       = &dwell_q;
  assign scan_end = tc && (ci_q == 2'd3);

  always_comb begin
    col_n = 3'd0;
    col_r = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s_q[r]) begin
        col_n = col_n + 3'd1;
        col_r = 2'(r);
      end
    end
    sum      = {1'b0, acc_n_q} + col_n;
    acc_n_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    acc_k_d  = (acc_n_q == 2'd0 && col_n != 3'd0) ? {col_r, ci_q} : acc_k_q;
    res_kind = (acc_n_d == 2'd0) ? R_NONE : (acc_n_d == 2'd1) ? R_SINGLE : R_MULTI;
    // Key index only distinguishes SINGLE results; keep it zero otherwise so compare is exact
    res_key  = (res_kind == R_SINGLE) ? acc_k_d : 4'd0;
    same     = (res_kind == prev_kind_q) && (res_key == prev_key_q);
    cnt_d    = !same ? 4'd1 : (stab_cnt_q < DB) ? stab_cnt_q + 4'd1 : stab_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m_q      <= '0;
      row_s_q      <= '0;
      dwell_q      <= '0;
      ci_q         <= '0;
      acc_n_q      <= '0;
      acc_k_q      <= '0;
      prev_kind_q  <= R_NONE;
      prev_key_q   <= '0;
      stab_cnt_q   <= '0;
      stab_kind_q  <= R_NONE;
      stab_key_q   <= '0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      entry_value  <= '0;
      entry_done   <= 1'b0;
      commit_value <= '0;
    end else begin
      key_valid  <= 1'b0;
      entry_done <= 1'b0;
      row_m_q    <= row_in;
      row_s_q    <= row_m_q;
      dwell_q    <= dwell_q + 1'b1;
      if (tc) begin
        ci_q <= ci_q + 2'd1;
        if (scan_end) begin
          acc_n_q     <= '0;
          acc_k_q     <= '0;
          prev_kind_q <= res_kind;
          prev_key_q  <= res_key;
          stab_cnt_q  <= cnt_d;
          if (cnt_d == DB) begin
            stab_kind_q <= res_kind;
            stab_key_q  <= res_key;
            // Only a release-to-single-press edge produces an event
            if (stab_kind_q == R_NONE && res_kind == R_SINGLE) begin
              key_valid <= 1'b1;
              key_code  <= res_key;
            end
          end
        end else begin
          acc_n_q <= acc_n_d;
          acc_k_q <= acc_k_d;
        end
      end
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          entry_value <= {entry_value[7:0], key_code};
        end else if (key_code == K_CLR) begin
          entry_value <= '0;
        end else if (key_code == K_ENT) begin
          commit_value <= entry_value;
          entry_done   <= 1'b1;
          entry_value  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner: behavioural key matrix, table of keystrokes,
// plus hand sequences for bounce, multi-key and mid-scan reset.
module tb_keypad_entry_scanner;
  localparam int SB = 2;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, entry_done;
  logic [11:0] entry_value, commit_value;

  int n_tests = 0;
  int n_fail  = 0;
  int kv_count = 0;

  keypad_entry_scanner #(.SCAN_BITS(SB), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .entry_value(entry_value),
    .entry_done(entry_done), .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid) kv_count++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Press key k until an event appears (bounded), capture state one cycle later, release and settle
  task automatic press(input int k, output logic seen, output logic [3:0] code,
                       output logic done, output logic [11:0] ent, output logic [11:0] com);
    seen = 1'b0;
    code = '0;
    pressed[k] = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        code = key_code;
      end
    end
    @(negedge clk);
    done = entry_done;
    ent  = entry_value;
    com  = commit_value;
    pressed[k] = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  typedef struct {
    int          k;
    logic [11:0] ent;
    logic        done;
    logic [11:0] com;
  } vec_t;

  vec_t        tv[8];
  logic        seen, done;
  logic [3:0]  code;
  logic [11:0] ent, com;
  logic [3:0]  ecol;
  int          kv0, nkv, lat;

  initial begin
    tv[0] = '{1,  12'h001, 1'b0, 12'h000};
    tv[1] = '{2,  12'h012, 1'b0, 12'h000};
    tv[2] = '{3,  12'h123, 1'b0, 12'h000};
    tv[3] = '{4,  12'h234, 1'b0, 12'h000};
    tv[4] = '{14, 12'h000, 1'b1, 12'h234};
    tv[5] = '{7,  12'h007, 1'b0, 12'h234};
    tv[6] = '{10, 12'h007, 1'b0, 12'h234};
    tv[7] = '{12, 12'h000, 1'b0, 12'h234};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst col_out", 32'(col_out), 32'hE);
    chk("rst key_valid", 32'(key_valid), 32'h0);
    chk("rst key_code", 32'(key_code), 32'h0);
    chk("rst entry_value", 32'(entry_value), 32'h0);
    chk("rst entry_done", 32'(entry_done), 32'h0);
    chk("rst commit_value", 32'(commit_value), 32'h0);

    // Held key 5: column rotation, single event, bounded latency
    pressed[5] = 1'b1;
    rst_n = 1'b1;
    nkv = 0;
    lat = -1;
    code = '0;
    for (int j = 0; j < 160; j++) begin
      if (j < 16) begin
        ecol = ~(4'b0001 << ((j / 4) % 4));
        chk($sformatf("col_out step %0d", j), 32'(col_out), 32'(ecol));
      end
      if (key_valid) begin
        nkv++;
        if (lat < 0) begin
          lat = j;
          code = key_code;
        end
      end
      @(negedge clk);
    end
    chk("hold5 events", 32'(nkv), 32'd1);
    chk("hold5 code", 32'(code), 32'd5);
    chk("hold5 latency ok", 32'(lat >= 0 && lat <= 3*16+3), 32'd1);
    pressed[5] = 1'b0;
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Key 3 toggling every scan never settles
    kv0 = kv_count;
    for (int s = 0; s < 8; s++) begin
      pressed[3] = ~pressed[3];
      repeat (16) @(negedge clk);
    end
    pressed[3] = 1'b0;
    repeat (80) @(negedge clk);
    chk("bounce events", 32'(kv_count - kv0), 32'd0);

    // Keystroke table: digits, Enter, spare, Clear
    for (int i = 0; i < 8; i++) begin
      kv0 = kv_count;
      press(tv[i].k, seen, code, done, ent, com);
      chk($sformatf("tv%0d seen", i), 32'(seen), 32'd1);
      chk($sformatf("tv%0d code", i), 32'(code), 32'(tv[i].k));
      chk($sformatf("tv%0d events", i), 32'(kv_count - kv0), 32'd1);
      chk($sformatf("tv%0d entry_done", i), 32'(done), 32'(tv[i].done));
      chk($sformatf("tv%0d entry_value", i), 32'(ent), 32'(tv[i].ent));
      chk($sformatf("tv%0d commit_value", i), 32'(com), 32'(tv[i].com));
    end
    chk("entry_done idle", 32'(entry_done), 32'd0);

    // Two keys, then one, then none: no event without passing through NONE
    kv0 = kv_count;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    repeat (96) @(negedge clk);
    pressed[1] = 1'b0;
    repeat (96) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (80) @(negedge clk);
    chk("multi events", 32'(kv_count - kv0), 32'd0);
    press(0, seen, code, done, ent, com);
    chk("after multi seen", 32'(seen), 32'd1);
    chk("after multi code", 32'(code), 32'd0);
    chk("after multi entry", 32'(ent), 32'h000);

    // Key 9 held across an asynchronous mid-dwell reset
    pressed[9] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    chk("k9 first seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    chk("k9 entry pre-reset", 32'(entry_value), 32'h009);
    #2 rst_n = 1'b0;
    #1;
    chk("async col_out", 32'(col_out), 32'hE);
    chk("async entry_value", 32'(entry_value), 32'h0);
    chk("async commit_value", 32'(commit_value), 32'h0);
    chk("async key_code", 32'(key_code), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    code = '0;
    kv0 = kv_count;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        code = key_code;
      end
    end
    @(negedge clk);
    chk("k9 post-reset seen", 32'(seen), 32'd1);
    chk("k9 post-reset code", 32'(code), 32'd9);
    chk("k9 post-reset entry", 32'(entry_value), 32'h009);
    repeat (64) @(negedge clk);
    chk("k9 post-reset events", 32'(kv_count - kv0), 32'd1);
    pressed[9] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
